i2s_rx: RTL and testbench
=========================

# i2s_rx

Receive-side counterpart of the I2S controller: deserializes an I2S stream (SCLK, LRCK, SDIN), all asynchronous to the system clock, into signed PCM samples tagged left/right. Samples are presented on a valid/ready port for the CPU memory-mapped I/O or an async FIFO. It closes the audio loop in the system: a bench can wire the transmitter's SCLK/LRCK/SDIN straight into this block and check every sample arrives in order.

## Interface
- BIT_DEPTH, 24: PCM sample width; MSB-first, left-justified within each LRCK half.
- SLOT_BITS, 32: SCLK cycles per LRCK half; bits after BIT_DEPTH are ignored.
- clk  in  1  system clock; all logic, single domain.
- rst_n  in  1  asynchronous, active-low reset.
- sclk  in  1  I2S bit clock; asynchronous, sampled by clk.
- lrck  in  1  word select; 0 = left, 1 = right; asynchronous.
- sdin  in  1  serial data; asynchronous.
- sample_data  out  BIT_DEPTH  captured sample, two's complement.
- sample_right  out  1  channel tag: 1 = right, 0 = left.
- sample_valid  out  1  sample_data/sample_right hold a sample.
- sample_ready  in  1  consumer accepts when valid && ready.
- overrun  out  1  sticky: a completed sample was dropped.
- overrun_clr  in  1  clears overrun (single-cycle pulse).

## Operation
- sclk, lrck, sdin each pass through a 2-FF synchronizer of equal depth, so they stay mutually aligned; a third sclk flop gives rise detection. All capture happens on a detected sclk rising edge.
- Each capture edge samples the synchronized lrck and sdin together.
- FSM states:
  - UNSYNC: reset state; waits for the first capture edge whose lrck differs from the previous capture edge's lrck; then goes to SHIFT.
  - SHIFT: shifts in BIT_DEPTH bits, MSB first.
  - SKIP: ignores bits until the next lrck change.
- LRCK change edge:
  - The bit at this edge is the previous slot's LSB/pad, so it is discarded (I2S one-bit delay).
  - Bit counter <= 0; channel <= new lrck; state <= SHIFT.
  - A change seen in SHIFT (short slot) aborts the partial word silently and restarts.
- SHIFT: each capture edge shifts sdin into the LSB and increments the counter. On the BIT_DEPTH-th bit, the word completes and the FSM goes to SKIP.
- Output register (single entry):
  - On completion, if !sample_valid, or sample_valid && sample_ready in the same cycle, load data and channel and assert valid.
  - Otherwise drop the new word, keep the held sample, and set overrun.
- overrun_clr and a new overrun in the same cycle: overrun stays 1.
- Reset (any time, including mid-word):
  - Outputs: sample_data = 0, sample_right = 0, sample_valid = 0, overrun = 0.
  - FSM = UNSYNC; synchronizers = 0.
  - No partial word is ever emitted.

## Timing
- Requirement: sclk high and low phases are each ≥ 3 clk periods. With clk 125 MHz, sclk is at most ~20 MHz.
- Pin sclk rise to capture: 3 clk cycles (2 sync + 1 edge-detect).
- Last data bit capture edge to sample_valid high: 1 clk cycle.
- sample_valid holds, with stable data, until the handshake cycle, then drops the next cycle unless a completion coincides.
- Throughput: one sample per LRCK half. Backpressure longer than one slot causes overrun.
- The first sample after reset or resync is the first full slot following an observed LRCK change.

## Structure
- Shared package/header `i2s_pkg`: BIT_DEPTH and SLOT_BITS defaults, LRCK channel encoding (CH_LEFT = 0, CH_RIGHT = 1), FSM state encodings. Shared with the transmitter.
- Sub-module `i2s_rx_sync`:
  - Inputs: the three pins.
  - Outputs: synchronized sdin and lrck, plus a one-cycle sclk_rise pulse.
  - Reused by any future I2S-input block.
- Top: FSM, bit counter (clog2(BIT_DEPTH+1) bits), shift register, output register, overrun flag.

## Test plan
- Loopback with the transmitter model: send left/right pairs -50…50 (24-bit, e.g. -50 = 24'hFFFFCE), ready tied 1 -> 202 samples received in order with tags alternating L,R; overrun = 0.
- Start mid-slot (sdin toggling before the first LRCK edge) -> no output until the first LRCK change; the first output is the next full slot's word.
- Hold ready = 0 for 3 slots after 24'h123456 (L), then send 24'h654321 (R) and 24'h0F0F0F (L) -> held value stays 24'h123456; overrun = 1; overrun_clr then clears it.
- Completion in the same cycle as a handshake (valid && ready) -> new word loaded with no gap and no overrun.
- Short slot (LRCK toggles after 10 bits) -> no partial emit; the following full 24'h800000 is received correctly.
- Assert rst_n low for 2 cycles mid-word -> all outputs 0 immediately; the first valid appears only after a new LRCK edge plus a full slot.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default word/slot sizes, channel encoding and the
// receiver FSM state encoding.
package i2s_pkg;

  localparam int unsigned I2S_BIT_DEPTH = 24;
  localparam int unsigned I2S_SLOT_BITS = 32;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_SKIP   = 2'd2
  } rx_state_e;

endpackage

// File: rtl/i2s_rx_if.sv
// Sample stream port: one captured PCM word plus channel tag on valid/ready.
interface i2s_rx_if
  import i2s_pkg::*;
#(
  parameter int unsigned BIT_DEPTH = I2S_BIT_DEPTH
) ();

  logic [BIT_DEPTH-1:0] sample_data;
  logic                 sample_right;
  logic                 sample_valid;
  logic                 sample_ready;

  modport master (
    output sample_data,
    output sample_right,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_right,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/i2s_rx_sync.sv
// Brings the three asynchronous I2S pins into the clk domain. All pins use the
// same synchronizer depth so lrck/sdin stay aligned with the sclk rise pulse.
module i2s_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic lrck,
  input  logic sdin,
  output logic lrck_sync,
  output logic sdin_sync,
  output logic sclk_rise
);

  logic [2:0] sclk_q;
  logic [1:0] lrck_q;
  logic [1:0] sdin_q;

  // Two-stage synchronizers; sclk carries one extra stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      lrck_q <= '0;
      sdin_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      lrck_q <= {lrck_q[0], lrck};
      sdin_q <= {sdin_q[0], sdin};
    end
  end

  assign lrck_sync = lrck_q[1];
  assign sdin_sync = sdin_q[1];
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: deserializes MSB-first, one-bit-delayed words per LRCK half
// into a single-entry valid/ready output register with a sticky overrun flag.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int unsigned BIT_DEPTH = I2S_BIT_DEPTH,
  parameter int unsigned SLOT_BITS = I2S_SLOT_BITS
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      sclk,
  input  logic      lrck,
  input  logic      sdin,
  i2s_rx_if.master  smp,
  output logic      overrun,
  input  logic      overrun_clr
);

  localparam int unsigned CW = $clog2(BIT_DEPTH + 1);

  if (SLOT_BITS <= BIT_DEPTH) begin : g_bad_slot
    $error("SLOT_BITS must exceed BIT_DEPTH to leave room for the delay bit");
  end

  logic                 lrck_s;
  logic                 sdin_s;
  logic                 cap;
  rx_state_e            state;
  rx_state_e            state_next;
  logic [CW-1:0]        bit_cnt;
  logic [BIT_DEPTH-2:0] shreg;
  logic [BIT_DEPTH-1:0] word;
  logic                 channel;
  logic                 lrck_prev;
  logic                 lrck_seen;
  logic                 lrck_change;
  logic                 word_done;
  logic                 load;

  i2s_rx_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .lrck      (lrck),
    .sdin      (sdin),
    .lrck_sync (lrck_s),
    .sdin_sync (sdin_s),
    .sclk_rise (cap)
  );

  // A change only counts once a previous capture exists, so a stream joined
  // mid-slot waits for a genuine slot boundary.
  assign lrck_change = cap && lrck_seen && (lrck_s != lrck_prev);
  assign word        = {shreg, sdin_s};
  assign load        = word_done && (!smp.sample_valid || smp.sample_ready);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_UNSYNC;
    else        state <= state_next;
  end

  // Next state: an LRCK change restarts from any state; SHIFT ends on the last bit.
  always_comb begin
    state_next = state;
    word_done  = 1'b0;
    if (lrck_change) begin
      state_next = ST_SHIFT;
    end else if (cap) begin
      case (state)
        ST_SHIFT: begin
          if (bit_cnt == CW'(BIT_DEPTH - 1)) begin
            word_done  = 1'b1;
            state_next = ST_SKIP;
          end
        end
        default: ;
      endcase
    end
  end

  // Capture datapath: lrck history, bit counter, shift register, channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lrck_prev <= 1'b0;
      lrck_seen <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      channel   <= CH_LEFT;
    end else begin
      if (cap) begin
        lrck_prev <= lrck_s;
        lrck_seen <= 1'b1;
      end
      if (lrck_change) begin
        bit_cnt <= '0;
        channel <= lrck_s;
      end else if (cap && state == ST_SHIFT) begin
        shreg   <= word[BIT_DEPTH-2:0];
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Output register and sticky overrun; a new overrun wins over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp.sample_data  <= '0;
      smp.sample_right <= 1'b0;
      smp.sample_valid <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      if (load) begin
        smp.sample_data  <= word;
        smp.sample_right <= channel;
        smp.sample_valid <= 1'b1;
      end else if (smp.sample_valid && smp.sample_ready) begin
        smp.sample_valid <= 1'b0;
      end
      if (word_done && !load) overrun <= 1'b1;
      else if (overrun_clr)   overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives an I2S transmitter model and checks received
// samples against a slot-level model of which words must arrive.
module tb_i2s_rx;
  import i2s_pkg::*;

  localparam int unsigned BD   = 24;
  localparam int unsigned SB   = 32;
  localparam int          HALF = 28;

  typedef struct {
    logic [BD-1:0] d;
    logic          r;
  } samp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic sclk, lrck, sdin;
  logic overrun, overrun_clr;

  i2s_rx_if #(.BIT_DEPTH(BD)) smp ();

  i2s_rx #(.BIT_DEPTH(BD), .SLOT_BITS(SB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk        (sclk),
    .lrck        (lrck),
    .sdin        (sdin),
    .smp         (smp.master),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #4 clk = ~clk;

  int    vectors     = 0;
  int    miscompares = 0;
  int    rx_count    = 0;
  samp_t exp_q[$];
  bit    known       = 1'b0;
  logic  last_ch     = 1'b0;
  logic  exp_ovr     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Consumer: every accepted sample must be the oldest expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && smp.sample_valid === 1'b1 && smp.sample_ready === 1'b1) begin
      chk("spurious_sample", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        samp_t e;
        e = exp_q.pop_front();
        chk("sample_data", 32'(smp.sample_data), 32'(e.d));
        chk("sample_right", 32'(smp.sample_right), 32'(e.r));
      end
      rx_count++;
    end
  end

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 smp.sample_ready = v;
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && exp_q.size() > 0; k++) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // One LRCK half: bit 0 is the delay bit, then the word MSB-first, then pad.
  task automatic send_slot(input logic ch, input logic [BD-1:0] w, input int nbits,
                           input int rst_bit, input bit late_ready);
    bit    emit;
    samp_t s;
    emit = known && (ch != last_ch) && (nbits >= int'(BD) + 1) && (rst_bit < 0);
    if (emit) begin
      if (!smp.sample_ready && exp_q.size() > 0 && !late_ready) begin
        exp_ovr = 1'b1;
      end else begin
        s.d = w;
        s.r = ch;
        exp_q.push_back(s);
      end
    end
    @(posedge clk);
    #3;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      lrck = ch;
      if (i >= 1 && i <= int'(BD)) sdin = w[BD-i];
      else                         sdin = 1'($urandom);
      if (i == rst_bit) begin
        rst_n = 1'b0;
        exp_q.delete();
        exp_ovr = 1'b0;
        #16;
        chk("rst_data", 32'(smp.sample_data), 32'd0);
        chk("rst_right", 32'(smp.sample_right), 32'd0);
        chk("rst_valid", 32'(smp.sample_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        #(HALF - 16);
      end else begin
        #HALF;
      end
      sclk = 1'b1;
      if (late_ready && i == int'(BD)) begin
        #11 smp.sample_ready = 1'b1;
        #11;
        chk("coinc_valid", 32'(smp.sample_valid), 32'd1);
        chk("coinc_data", 32'(smp.sample_data), 32'(w));
        chk("coinc_right", 32'(smp.sample_right), 32'(ch));
        chk("coinc_overrun", 32'(overrun), 32'd0);
        #(HALF - 22);
      end else begin
        #HALF;
      end
    end
    known   = 1'b1;
    last_ch = ch;
  endtask

  initial begin
    rst_n            = 1'b0;
    sclk             = 1'b1;
    lrck             = 1'b0;
    sdin             = 1'b0;
    overrun_clr      = 1'b0;
    smp.sample_ready = 1'b1;
    #20;
    chk("reset_data", 32'(smp.sample_data), 32'd0);
    chk("reset_right", 32'(smp.sample_right), 32'd0);
    chk("reset_valid", 32'(smp.sample_valid), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    #3 rst_n = 1'b1;

    // Join mid-slot: a partial right slot yields nothing.
    send_slot(CH_RIGHT, BD'($urandom), 15, -1, 1'b0);
    #100;
    chk("midslot_valid", 32'(smp.sample_valid), 32'd0);

    // Loopback: left words -50..50 with random right words.
    for (int v = -50; v <= 50; v++) begin
      send_slot(CH_LEFT, BD'(v), SB, -1, 1'b0);
      send_slot(CH_RIGHT, BD'($urandom), SB, -1, 1'b0);
    end
    drain();
    chk("loop_count", 32'(rx_count), 32'd202);
    chk("loop_overrun", 32'(overrun), 32'(exp_ovr));

    // Backpressure across three slots.
    set_ready(1'b0);
    send_slot(CH_LEFT, 24'h123456, SB, -1, 1'b0);
    send_slot(CH_RIGHT, 24'h654321, SB, -1, 1'b0);
    send_slot(CH_LEFT, 24'h0F0F0F, SB, -1, 1'b0);
    chk("bp_data", 32'(smp.sample_data), 32'h123456);
    chk("bp_right", 32'(smp.sample_right), 32'(CH_LEFT));
    chk("bp_valid", 32'(smp.sample_valid), 32'd1);
    chk("bp_overrun", 32'(overrun), 32'(exp_ovr));
    @(posedge clk);
    #1 overrun_clr = 1'b1;
    @(posedge clk);
    #1 overrun_clr = 1'b0;
    exp_ovr = 1'b0;
    chk("ovr_clear", 32'(overrun), 32'(exp_ovr));
    set_ready(1'b1);
    drain();

    // Completion coincident with handshake.
    set_ready(1'b0);
    send_slot(CH_RIGHT, 24'hA5A5A5, SB, -1, 1'b0);
    send_slot(CH_LEFT, 24'h5A5A5A, SB, -1, 1'b1);
    drain();
    chk("coinc_overrun_end", 32'(overrun), 32'(exp_ovr));

    // Short slot aborts silently; next full slot is intact.
    send_slot(CH_RIGHT, BD'($urandom), 11, -1, 1'b0);
    send_slot(CH_LEFT, 24'h800000, SB, -1, 1'b0);
    drain();

    // Reset mid-word while a sample is held.
    set_ready(1'b0);
    send_slot(CH_RIGHT, 24'h13579B, SB, -1, 1'b0);
    send_slot(CH_LEFT, BD'($urandom), SB, 9, 1'b0);
    set_ready(1'b1);
    send_slot(CH_RIGHT, BD'($urandom), SB, -1, 1'b0);
    send_slot(CH_LEFT, BD'($urandom), SB, -1, 1'b0);
    drain();
    chk("final_overrun", 32'(overrun), 32'(exp_ovr));
    chk("final_valid", 32'(smp.sample_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
